window_switch: RTL
==================

WINDOW_SWITCH -- requirements
Module: window_switch

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one data word.
REQ-002 Parameter CONV_UNITS, default 8, output lanes per beat.
REQ-003 Parameter KERNEL_SIZE_MAX, default 3, maximum number of shifted windows per input beat; IN_SIZE = CONV_UNITS+KERNEL_SIZE_MAX-1 (derived, not overridable).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 kernel_size  input  $clog2(KERNEL_SIZE_MAX+1)  windows to emit for the beat being accepted.
REQ-007 s_valid  input  1  input beat valid.
REQ-008 s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-009 s_data  input  DATA_WIDTH*IN_SIZE  input words; word 0 at LSBs.
REQ-010 m_valid  output  1  output window valid.
REQ-011 m_ready  input  1  downstream accepts window when m_valid && m_ready.
REQ-012 m_data  output  DATA_WIDTH*CONV_UNITS  lane i = s_data word (i+m_sel) of held beat.
REQ-013 m_sel  output  $clog2(KERNEL_SIZE_MAX)  shift index of current window (min width 1).
REQ-014 m_last  output  1  high on final window of the held beat.

Function
REQ-015 Two states: IDLE (no beat held) and SHIFT (beat held, windows being emitted).
REQ-016 s_ready SHALL be 1 in IDLE, and in SHIFT only when m_last && m_ready (back-to-back acceptance); 0 otherwise.
REQ-017 On acceptance, s_data and effective kernel size K SHALL be registered; K = 1 if kernel_size==0, KERNEL_SIZE_MAX if kernel_size>KERNEL_SIZE_MAX, else kernel_size.
REQ-018 Latency: first window (m_sel=0) SHALL present m_valid=1 on the cycle after acceptance.
REQ-019 Each m_valid && m_ready handshake SHALL advance m_sel by 1; m_sel runs 0..K-1, m_last=1 exactly when m_sel==K-1.
REQ-020 Handshake on m_last with no new beat accepted SHALL go to IDLE, m_valid=0 next cycle; with a new beat accepted the same cycle, SHALL stay in SHIFT with m_sel=0 and the new data next cycle (no bubble).
REQ-021 While m_valid && !m_ready, m_data, m_sel, m_last SHALL hold stable; m_valid SHALL not drop.
REQ-022 m_data SHALL be a pure lane selection of held words, no arithmetic, no sign change.
REQ-023 kernel_size and s_data changes while not accepting SHALL not affect the held beat.
REQ-024 K=1 SHALL emit exactly one window with m_sel=0, m_last=1.

Reset
REQ-025 rst SHALL force state IDLE, m_valid=0, m_last=0, m_sel=0, m_data=0, held data=0, s_ready=0 during the reset cycle.
REQ-026 s_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-027 rst mid-SHIFT SHALL discard the held beat and remaining windows; no window of it appears after reset.

Configuration
REQ-028 Macro WINDOW_SWITCH_CLEAR_EN: when defined, m_data SHALL read 0 whenever m_valid=0 (including after final handshake and in IDLE).
REQ-029 Without WINDOW_SWITCH_CLEAR_EN, m_data SHALL retain its last value while m_valid=0; all other behaviour identical.

Verification
REQ-030 Reset, then s_data words 0..9 = {15360,16384,16896,17408,17664,17920,18176,18432,18560,18688}, kernel_size=3, m_ready=1 -> three windows: m_sel=0 lanes 15360..18432, m_sel=1 lanes 16384..18560, m_sel=2 lanes 16896..18688 with m_last=1, on three consecutive cycles starting 1 cycle after accept.
REQ-031 Same beat followed immediately by second beat words {48128,49152,49664,50176,50432,50688,50944,51200,51328,51456}, s_valid held -> s_ready=1 only on m_last cycle; second beat m_sel=0 window (48128..51200) follows first m_last with no gap.
REQ-032 kernel_size=0 then kernel_size=7 -> one window (m_last=1, m_sel=0), then three windows (clamped K=3).
REQ-033 m_ready toggled 1,0,0,1,1 during K=3 beat -> outputs stable during stalls; exactly three handshakes; s_ready=0 throughout until m_last handshake.
REQ-034 rst asserted while m_sel=1 -> next cycle m_valid=0, m_data=0, s_ready=0; after release s_ready=1 and no stale window emitted.
REQ-035 Build with and without WINDOW_SWITCH_CLEAR_EN -> after final handshake m_data=0 vs m_data=last window (16896..18688).

Source files
------------

// File: rtl/window_switch_if.sv
// rtl/window_switch_if.sv - handshake bundle between window_switch and its neighbours
//
// Purpose: groups the input-beat stream and the output-window stream of
// window_switch into one interface.
//   slave  modport : the window_switch view (consumes s_*, produces m_*)
//   master modport : the environment view (produces s_*, consumes m_*)
// Signals:
//   kernel_size  windows requested for the beat being accepted
//   s_valid/s_ready/s_data           input beat stream, word 0 at LSBs
//   m_valid/m_ready/m_data/m_sel/m_last  output window stream
interface window_switch_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int CONV_UNITS      = 8,
  parameter int KERNEL_SIZE_MAX = 3
) ();
  localparam int IN_SIZE = CONV_UNITS + KERNEL_SIZE_MAX - 1;
  localparam int KS_W    = $clog2(KERNEL_SIZE_MAX + 1);
  localparam int SEL_W   = (KERNEL_SIZE_MAX > 1) ? $clog2(KERNEL_SIZE_MAX) : 1;

  logic [KS_W-1:0]                  kernel_size;
  logic                             s_valid;
  logic                             s_ready;
  logic [DATA_WIDTH*IN_SIZE-1:0]    s_data;
  logic                             m_valid;
  logic                             m_ready;
  logic [DATA_WIDTH*CONV_UNITS-1:0] m_data;
  logic [SEL_W-1:0]                 m_sel;
  logic                             m_last;

  modport slave (
    input  kernel_size, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sel, m_last
  );

  modport master (
    output kernel_size, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sel, m_last
  );
endinterface

// File: rtl/window_switch.sv
// rtl/window_switch.sv - emits K shifted CONV_UNITS-wide windows of each held input beat
//
// Purpose: accepts one IN_SIZE-word beat, then presents windows m_sel=0..K-1
// where lane i of window j is input word i+j. Back-to-back beats are accepted
// on the handshake of the final window so there is no bubble between beats.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - window_switch_if.slave (kernel_size, s_* input beat, m_* output window)
// Configuration macro:
//   WINDOW_SWITCH_CLEAR_EN - when defined, m_data reads 0 whenever m_valid=0;
//                            otherwise m_data keeps the last window shown.
module window_switch #(
  parameter int DATA_WIDTH      = 16,
  parameter int CONV_UNITS      = 8,
  parameter int KERNEL_SIZE_MAX = 3
) (
  input  logic           clk,
  input  logic           rst,
  window_switch_if.slave bus
);
  localparam int IN_SIZE = CONV_UNITS + KERNEL_SIZE_MAX - 1;
  localparam int KS_W    = $clog2(KERNEL_SIZE_MAX + 1);
  localparam int SEL_W   = (KERNEL_SIZE_MAX > 1) ? $clog2(KERNEL_SIZE_MAX) : 1;
  localparam int IN_W    = DATA_WIDTH * IN_SIZE;
  localparam int OUT_W   = DATA_WIDTH * CONV_UNITS;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   data_q, data_d;
  logic [OUT_W-1:0]  win_q, win_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  klast_q, klast_d;   // K-1 of the held beat

  logic [KS_W-1:0]   k_eff;
  logic [SEL_W-1:0]  klast_new;
  logic [SEL_W-1:0]  sel_nxt;
  logic [OUT_W-1:0]  win_nxt;
  logic              last;
  logic              hs;
  logic              s_ready;
  logic              accept;

  // Clamp the requested window count into 1..KERNEL_SIZE_MAX.
  always_comb begin
    k_eff = bus.kernel_size;
    if (bus.kernel_size == '0) begin
      k_eff = KS_W'(1);
    end else if (bus.kernel_size > KS_W'(KERNEL_SIZE_MAX)) begin
      k_eff = KS_W'(KERNEL_SIZE_MAX);
    end
  end

  assign klast_new = SEL_W'(k_eff - KS_W'(1));
  assign sel_nxt   = sel_q + SEL_W'(1);
  // Window j is the held beat shifted down by j words; only the low lanes survive.
  assign win_nxt   = OUT_W'(data_q >> (DATA_WIDTH * sel_nxt));

  assign last    = (state_q == SHIFT) && (sel_q == klast_q);
  assign hs      = (state_q == SHIFT) && bus.m_ready;
  // Gated by rst so nothing is accepted during the reset cycle itself.
  assign s_ready = !rst && ((state_q == IDLE) || (last && bus.m_ready));
  assign accept  = bus.s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    win_d   = win_q;
    sel_d   = sel_q;
    klast_d = klast_q;
    if (accept) begin
      // Covers both the IDLE load and the back-to-back load on the final handshake.
      state_d = SHIFT;
      data_d  = bus.s_data;
      klast_d = klast_new;
      sel_d   = '0;
      win_d   = bus.s_data[OUT_W-1:0];
    end else if (hs) begin
      if (last) begin
        state_d = IDLE;
        sel_d   = '0;
      end else begin
        sel_d = sel_nxt;
        win_d = win_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      win_q   <= '0;
      sel_q   <= '0;
      klast_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      klast_q <= klast_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = (state_q == SHIFT);
  assign bus.m_sel   = sel_q;
  assign bus.m_last  = last;
`ifdef WINDOW_SWITCH_CLEAR_EN
  assign bus.m_data  = (state_q == SHIFT) ? win_q : '0;
`else
  assign bus.m_data  = win_q;
`endif
endmodule
